// File: rtl/baud_rate_detector.sv
// Auto-baud detector: times a 0x55 calibration character on RXD and derives the
// divisor for a 16x-oversampling baud generator (period = DIVISOR+1).
module baud_rate_detector #(
   parameter int CNT_W     = 24,
   parameter int TOL_SHIFT = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        RXD,
   input  logic        START,
   output logic [15:0] DIVISOR_OUT,
   output logic        DONE,
   output logic        ERROR,
   output logic        BUSY
);

   typedef enum logic [1:0] {IDLE, ARMED, MEASURE, RESULT} state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = '1;

   state_t            r_state, w_state_nxt;
   logic              r_sync1, r_rx_s, r_rx_d;
   logic [CNT_W-1:0]  r_t, r_seg, r_w0;
   logic [3:0]        r_ecnt;
   logic              r_err;
   logic [15:0]       r_div;
   logic              r_done, r_error;

   logic [CNT_W-1:0]  w_t_nxt, w_seg_nxt, w_w0_nxt;
   logic [3:0]        w_ecnt_nxt;
   logic              w_err_nxt;
   logic [15:0]       w_div_nxt;
   logic              w_done_nxt, w_error_nxt;

   logic              w_fall, w_rise, w_edge;
   logic [CNT_W-1:0]  w_t_inc, w_seg_inc, w_tol, w_lo;
   logic [CNT_W:0]    w_hi, w_sum, w_q;
   logic              w_seg_bad, w_q_bad;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
         r_rx_d  <= 1'b1;
      end else begin
         r_sync1 <= RXD;
         r_rx_s  <= r_sync1;
         r_rx_d  <= r_rx_s;
      end
   end

   assign w_fall = !r_rx_s &&  r_rx_d;
   assign w_rise =  r_rx_s && !r_rx_d;
   assign w_edge = w_fall || w_rise;

   assign w_t_inc   = (r_t   == MAX_CNT) ? r_t   : r_t   + CNT_W'(1);
   assign w_seg_inc = (r_seg == MAX_CNT) ? r_seg : r_seg + CNT_W'(1);

   // Segment length includes the edge cycle, so every segment is measured alike.
   assign w_tol     = r_w0 >> TOL_SHIFT;
   assign w_lo      = r_w0 - w_tol;
   assign w_hi      = {1'b0, r_w0} + {1'b0, w_tol};
   assign w_seg_bad = (w_seg_inc < w_lo) || ({1'b0, w_seg_inc} > w_hi);

   // T spans 8 bit times = 128 sixteenth-bit units; round to nearest.
   assign w_sum   = {1'b0, r_t} + (CNT_W+1)'(64);
   assign w_q     = w_sum >> 7;
   assign w_q_bad = (w_q == '0) || (32'(w_q) > 32'd65536);

   always_comb begin
      w_state_nxt = r_state;
      w_t_nxt     = r_t;
      w_seg_nxt   = r_seg;
      w_w0_nxt    = r_w0;
      w_ecnt_nxt  = r_ecnt;
      w_err_nxt   = r_err;
      w_div_nxt   = r_div;
      w_done_nxt  = 1'b0;
      w_error_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (START) begin
               w_state_nxt = ARMED;
               w_t_nxt     = '0;
               w_seg_nxt   = '0;
               w_ecnt_nxt  = '0;
               w_err_nxt   = 1'b0;
            end
         end
         ARMED: begin
            if (START || w_fall) begin
               w_state_nxt = START ? ARMED : MEASURE;
               w_t_nxt     = '0;
               w_seg_nxt   = '0;
               w_ecnt_nxt  = '0;
               w_err_nxt   = 1'b0;
            end
         end
         MEASURE: begin
            if (START) begin
               w_state_nxt = ARMED;
               w_t_nxt     = '0;
               w_seg_nxt   = '0;
               w_ecnt_nxt  = '0;
               w_err_nxt   = 1'b0;
            end else begin
               w_t_nxt   = w_t_inc;
               w_seg_nxt = w_seg_inc;
               if (w_edge) begin
                  w_ecnt_nxt = r_ecnt + 4'd1;
                  w_seg_nxt  = CNT_W'(1);
                  if (r_ecnt == 4'd0)
                     w_w0_nxt = w_seg_inc;
                  else if (w_seg_bad)
                     w_err_nxt = 1'b1;
                  if (r_ecnt == 4'd7)
                     w_state_nxt = RESULT;
               end
               if (w_t_inc == MAX_CNT) begin
                  w_state_nxt = RESULT;
                  w_err_nxt   = 1'b1;
               end
            end
         end
         RESULT: begin
            w_state_nxt = IDLE;
            if (r_err || w_q_bad) begin
               w_error_nxt = 1'b1;
            end else begin
               w_done_nxt = 1'b1;
               w_div_nxt  = 16'(w_q - (CNT_W+1)'(1));
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_t     <= '0;
         r_seg   <= '0;
         r_w0    <= '0;
         r_ecnt  <= '0;
         r_err   <= 1'b0;
         r_div   <= 16'h0000;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_t     <= w_t_nxt;
         r_seg   <= w_seg_nxt;
         r_w0    <= w_w0_nxt;
         r_ecnt  <= w_ecnt_nxt;
         r_err   <= w_err_nxt;
         r_div   <= w_div_nxt;
         r_done  <= w_done_nxt;
         r_error <= w_error_nxt;
      end
   end

   assign DIVISOR_OUT = r_div;
   assign DONE        = r_done;
   assign ERROR       = r_error;
   assign BUSY        = (r_state != IDLE);

endmodule

// File: tb/tb_baud_rate_detector.sv
// Scoreboard bench for baud_rate_detector: stimulus queues expected DONE/ERROR
// results, a monitor pops and compares on every pulse.
module tb_baud_rate_detector;

   typedef struct packed {
      logic        is_err;
      logic [15:0] div;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST_N, RXD, START;
   logic [15:0] DIVISOR_OUT;
   logic        DONE, ERROR, BUSY;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t mon_e;

   always #5 CLK = ~CLK;

   baud_rate_detector #(.CNT_W(12), .TOL_SHIFT(2)) dut (
      .CLK(CLK), .RST_N(RST_N), .RXD(RXD), .START(START),
      .DIVISOR_OUT(DIVISOR_OUT), .DONE(DONE), .ERROR(ERROR), .BUSY(BUSY)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic expect_res(input logic is_err, input logic [15:0] div);
      exp_t e;
      e.is_err = is_err;
      e.div    = div;
      q.push_back(e);
   endtask

   always @(negedge CLK) begin
      if (RST_N && (DONE || ERROR)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse actual done=%0b error=%0b required none", DONE, ERROR);
         end else begin
            mon_e = q.pop_front();
            chk("pulse_kind", {30'd0, DONE, ERROR}, mon_e.is_err ? 32'd1 : 32'd2);
            chk("divisor", {16'd0, DIVISOR_OUT}, {16'd0, mon_e.div});
            chk("busy_at_pulse", {31'd0, BUSY}, 32'd0);
         end
      end
   end

   task automatic wait_drain(input int bound, input string name);
      int n = 0;
      while (q.size() != 0 && n < bound) begin
         @(negedge CLK);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s actual=timeout pending=%0d required=0", name, q.size());
         q.delete();
      end
      repeat (4) @(negedge CLK);
   endtask

   task automatic pulse_start();
      @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic hold(input logic v, input int cyc);
      RXD = v;
      repeat (cyc) @(negedge CLK);
   endtask

   task automatic send_byte(input logic [7:0] b, input int bt);
      hold(1'b0, bt);
      for (int i = 0; i < 8; i++) hold(b[i], bt);
      hold(1'b1, bt);
   endtask

   initial begin
      RST_N = 1'b0;
      RXD   = 1'b1;
      START = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_divisor", {16'd0, DIVISOR_OUT}, 32'd0);
      chk("rst_done",    {31'd0, DONE},  32'd0);
      chk("rst_error",   {31'd0, ERROR}, 32'd0);
      chk("rst_busy",    {31'd0, BUSY},  32'd0);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);

      // 64 CLK/bit: T=512 -> Q=4 -> divisor 3
      pulse_start();
      chk("busy_armed", {31'd0, BUSY}, 32'd1);
      expect_res(1'b0, 16'd3);
      send_byte(8'h55, 64);
      wait_drain(200, "drain_64");

      // 70 CLK/bit: T=560 -> Q=(624>>7)=4 -> divisor 3
      pulse_start();
      expect_res(1'b0, 16'd3);
      send_byte(8'h55, 70);
      wait_drain(200, "drain_70");

      // 32 CLK/bit: T=256 -> Q=2 -> divisor 1
      pulse_start();
      expect_res(1'b0, 16'd1);
      send_byte(8'h55, 32);
      wait_drain(200, "drain_32");

      // 0x5D has a 3-bit high run; the 8th edge comes from the next frame's start bit
      pulse_start();
      expect_res(1'b1, 16'd1);
      send_byte(8'h5D, 64);
      send_byte(8'h55, 64);
      wait_drain(200, "drain_5d");

      // Line stuck low: T saturates at 4095 -> timeout error
      pulse_start();
      expect_res(1'b1, 16'd1);
      RXD = 1'b0;
      wait_drain(5000, "drain_timeout");
      hold(1'b1, 10);

      // 16 CLK/bit: T=128 -> Q=1 -> divisor 0
      pulse_start();
      expect_res(1'b0, 16'd0);
      send_byte(8'h55, 16);
      wait_drain(200, "drain_16");

      // Abort after 4 edges, then fresh 0x55 at 32 CLK/bit -> single DONE, divisor 1
      pulse_start();
      hold(1'b0, 64);
      hold(1'b1, 64);
      hold(1'b0, 64);
      hold(1'b1, 64);
      hold(1'b0, 30);
      pulse_start();
      chk("busy_after_abort", {31'd0, BUSY}, 32'd1);
      hold(1'b0, 20);
      hold(1'b1, 50);
      expect_res(1'b0, 16'd1);
      send_byte(8'h55, 32);
      wait_drain(200, "drain_abort");

      // Reset mid-measurement clears outputs at once; no START afterwards -> no DONE
      pulse_start();
      hold(1'b0, 64);
      hold(1'b1, 20);
      chk("busy_measuring", {31'd0, BUSY}, 32'd1);
      RST_N = 1'b0;
      #1;
      chk("mid_rst_divisor", {16'd0, DIVISOR_OUT}, 32'd0);
      chk("mid_rst_busy",    {31'd0, BUSY},  32'd0);
      chk("mid_rst_done",    {31'd0, DONE},  32'd0);
      chk("mid_rst_error",   {31'd0, ERROR}, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      hold(1'b1, 10);
      send_byte(8'h55, 64);
      repeat (20) @(negedge CLK);
      chk("idle_busy",    {31'd0, BUSY}, 32'd0);
      chk("idle_divisor", {16'd0, DIVISOR_OUT}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/baud_rate_detector.md
BAUD_RATE_DETECTOR -- requirements
Module: baud_rate_detector

Interface
REQ-001 SHALL have parameter CNT_W, default 24: width of the elapsed-time and segment counters.
REQ-002 SHALL have parameter TOL_SHIFT, default 2: segment tolerance is W0>>TOL_SHIFT, i.e. ±25%.
REQ-003 SHALL have port CLK, input, 1 bit: the single global clock; all flops are rising-edge.
REQ-004 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port RXD, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port START, input, 1 bit: single-cycle arm request.
REQ-007 SHALL have port DIVISOR_OUT, output, 16 bits: measured divisor for the 16x-oversampling baud generator, whose counter period is DIVISOR+1.
REQ-008 SHALL have port DONE, output, 1 bit: one-cycle pulse indicating that DIVISOR_OUT was updated.
REQ-009 SHALL have port ERROR, output, 1 bit: one-cycle pulse indicating that the measurement was rejected.
REQ-010 SHALL have port BUSY, output, 1 bit: high while the state is not IDLE.

Function
REQ-011 SHALL synchronise RXD through two flops; all edge detection uses rx_s and its one-cycle-delayed copy rx_d.
REQ-012 SHALL define a fall as rx_s=0 and rx_d=1, and a rise as rx_s=1 and rx_d=0.
REQ-013 SHALL implement the states IDLE, ARMED, MEASURE and RESULT.
REQ-014 IDLE: on START, the FSM SHALL go to ARMED; RXD activity SHALL be ignored.
REQ-015 ARMED: on a fall, the FSM SHALL go to MEASURE, clearing T, SEG and the edge count, and clearing the error flag.
REQ-016 MEASURE: each cycle, T and SEG SHALL increment, saturating at 2^CNT_W-1.
REQ-017 MEASURE: on each edge, the edge count SHALL increment and SEG SHALL restart at 1.
REQ-018 Edge 1 (rising, end of start bit) SHALL latch W0=SEG, taken before SEG restarts.
REQ-019 Edges 2..8 SHALL flag an error if SEG < W0-(W0>>TOL_SHIFT) or SEG > W0+(W0>>TOL_SHIFT).
REQ-020 On the 8th edge, the FSM SHALL go to RESULT with T frozen, so that T equals 8 bit times in CLK cycles; the expected calibration character is 0x55, LSB first.
REQ-021 An error flag set on edges 2..7 SHALL be held and reported in RESULT; measurement continues to the 8th edge.
REQ-022 In MEASURE, if T saturates, the FSM SHALL go to RESULT immediately with the error flag set (timeout).
REQ-023 RESULT SHALL last one cycle and compute Q=(T+64)>>7 in CNT_W+1 bits, i.e. bit time rounded to the nearest 16-cycle unit.
REQ-024 RESULT: the FSM SHALL raise an error if Q=0 or Q>65536.
REQ-025 On exit from RESULT with no error, the block SHALL register DIVISOR_OUT=Q-1, pulse DONE for one cycle, and return to IDLE.
REQ-026 On exit from RESULT with an error, the block SHALL pulse ERROR for one cycle, hold DIVISOR_OUT unchanged, and return to IDLE.
REQ-027 DONE and ERROR SHALL never be high in the same cycle.
REQ-028 START in ARMED or MEASURE SHALL abort and restart in ARMED, with counters cleared and no DONE/ERROR pulse.
REQ-029 START in RESULT SHALL be ignored.
REQ-030 An edge in the same cycle as START while in MEASURE SHALL be discarded; START wins.
REQ-031 Latency: DONE/ERROR SHALL assert on the second rising CLK after the cycle in which the 8th edge is detected on rx_s.

Reset
REQ-032 RST_N low SHALL asynchronously force state IDLE, both sync flops and rx_d to 1, and T, SEG, W0 and the edge count to 0.
REQ-033 RST_N low SHALL force DIVISOR_OUT to 16'h0000 and DONE, ERROR and BUSY to 0.
REQ-034 Reset asserted mid-measurement SHALL discard the measurement; after release, the block SHALL stay in IDLE until START.

Verification
REQ-035 START, then 0x55 at 64 CLK/bit -> DONE one pulse, DIVISOR_OUT=3, ERROR=0, BUSY falls with DONE.
REQ-036 START, then 0x55 at 70 CLK/bit (T=560, Q=4) -> DIVISOR_OUT=3; at 16 CLK/bit -> DIVISOR_OUT=0.
REQ-037 START, then 0x5D at 64 CLK/bit (3-bit high segment) -> ERROR pulse, DIVISOR_OUT keeps its previous value.
REQ-038 START, then RXD held low after the start edge with CNT_W=12 -> ERROR pulse when T reaches 4095.
REQ-039 START, then 0x55 with START re-pulsed after 4 edges, followed by a fresh 0x55 at 32 CLK/bit -> a single DONE, DIVISOR_OUT=1.
REQ-040 RST_N pulsed low during MEASURE -> all outputs 0 immediately; a later 0x55 without START -> no DONE.
